// File: rtl/spi_pkg.sv
// Shared types and mode constants for the SPI receive slice.
package spi_pkg;

  // Receiver FSM: IDLE between frames, ACTIVE while chip select is low.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Clock polarity encodings (idle level of sclk).
  localparam int CPOL_IDLE_LOW  = 0;
  localparam int CPOL_IDLE_HIGH = 1;

  // Clock phase encodings (which sclk edge samples mosi).
  localparam int CPHA_LEADING   = 0;
  localparam int CPHA_TRAILING  = 1;

  // The sample edge is a rising sclk edge when polarity and phase "agree":
  // idle-low/leading and idle-high/trailing both sample on the rise.
  function automatic logic sample_on_rise(input int cpol, input int cpha);
    return ((cpol == CPOL_IDLE_LOW) == (cpha == CPHA_LEADING));
  endfunction

endpackage

// File: rtl/spi_sync.sv
// N-stage flip-flop synchronizer with a parameterized reset value.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  // Shift the asynchronous input through the chain; reset to the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      ff_q <= {STAGES{RST_VAL}};
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: synchronizes sclk/mosi/cs into the clk domain,
// deserializes DATA_W-bit words and presents them on a valid/ready port.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  output logic              frame_err,
  output logic              busy
);

  localparam int             CW        = $clog2(DATA_W + 1);
  localparam logic [CW-1:0]  LAST_BIT  = CW'(DATA_W - 1);
  localparam logic           SCLK_IDLE = (CPOL == CPOL_IDLE_HIGH);
  localparam logic           ON_RISE   = sample_on_rise(CPOL, CPHA);

  logic sclk_s, mosi_s, cs_s;
  logic sclk_prev_q, cs_prev_q;

  state_e state_q, state_d;

  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] shift_next;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d;

  logic sclk_rise, sclk_fall, sample_edge;
  logic cs_fall, cs_rise;
  logic shift_en, word_done;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sync_sclk (
    .clk (clk),
    .rst (rst),
    .d_i (sclk),
    .q_o (sclk_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk (clk),
    .rst (rst),
    .d_i (mosi),
    .q_o (mosi_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk (clk),
    .rst (rst),
    .d_i (cs),
    .q_o (cs_s)
  );

  // One-cycle delayed copies of synchronized sclk and cs for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_prev_q <= SCLK_IDLE;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_rise   = sclk_s & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_s & sclk_prev_q;
  assign sample_edge = ON_RISE ? sclk_rise : sclk_fall;
  assign cs_fall     = ~cs_s & cs_prev_q;
  assign cs_rise     = cs_s & ~cs_prev_q;

  // A sample edge counts only with cs low; the frame-opening cycle is
  // accepted too so a very early first edge is not lost.
  assign shift_en  = sample_edge & ~cs_s & ((state_q == ACTIVE) | cs_fall);
  assign word_done = shift_en & (bit_cnt_q == LAST_BIT);

  // Shift register contents after inserting the current mosi bit.
  always_comb begin
    shift_next = shift_q;
    if (MSB_FIRST != 0) begin
      shift_next = {shift_q[DATA_W-2:0], mosi_s};
    end else begin
      shift_next = {mosi_s, shift_q[DATA_W-1:1]};
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: frame boundaries follow the synchronized chip select.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = ACTIVE;
      ACTIVE:  if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q == ACTIVE);
  end

  // Deserializer and output-port next state: shift, word handoff,
  // overrun on a blocked handoff, frame error on a truncated word.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    if (shift_en) begin
      shift_d = shift_next;
      if (word_done) begin
        bit_cnt_d = '0;
        // The slot is free if empty or being drained this very cycle.
        if (!rx_valid_q || rx_ready) begin
          rx_data_d  = shift_next;
          rx_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end else if ((state_q == ACTIVE) && cs_rise) begin
      bit_cnt_d   = '0;
      shift_d     = '0;
      frame_err_d = (bit_cnt_q != '0);
    end
  end

  // Deserializer and output-port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: directed frames plus randomized frames checked
// against a word-level model of the receive port.
module tb_spi_slave_rx;

  localparam int DATA_W = 8;
  localparam int SYNC   = 2;
  localparam int HALF   = 4;   // clk cycles per sclk phase (8 clk per bit)

  logic              clk = 1'b0;
  logic              rst;
  logic              sclk;
  logic              mosi;
  logic              cs;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              overrun;
  logic              frame_err;
  logic              busy;

  always #5 clk = ~clk;

  spi_slave_rx #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC),
    .CPOL        (0),
    .CPHA        (0),
    .MSB_FIRST   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .mosi      (mosi),
    .cs        (cs),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .overrun   (overrun),
    .frame_err (frame_err),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Port observer: records accepted words, pulses and hold violations.
  logic              prev_valid = 1'b0;
  logic [DATA_W-1:0] prev_data  = '0;
  int                ovr_cnt    = 0;
  int                ferr_cnt   = 0;
  int                vld_cyc    = 0;
  int                busy_cyc   = 0;
  int                hold_viol  = 0;
  logic [DATA_W-1:0] acc_q[$];

  always @(negedge clk) begin
    if (overrun)   ovr_cnt  <= ovr_cnt + 1;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (!rst) begin
      if (prev_valid && rx_ready) acc_q.push_back(prev_data);
      if (prev_valid && !rx_ready && (!rx_valid || rx_data !== prev_data))
        hold_viol <= hold_viol + 1;
      if (rx_valid) vld_cyc  <= vld_cyc + 1;
      if (busy)     busy_cyc <= busy_cyc + 1;
    end
    prev_valid <= rst ? 1'b0 : rx_valid;
    prev_data  <= rx_data;
  end

  // Drive inputs a little after the falling edge, after the observer.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic spi_bit(input logic b);
    mosi = b;
    step(HALF);
    sclk = 1'b1;
    step(HALF);
    sclk = 1'b0;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w);
    for (int i = DATA_W - 1; i >= 0; i--) spi_bit(w[i]);
  endtask

  task automatic frame_start();
    cs = 1'b0;
    step(HALF);
  endtask

  task automatic frame_end();
    step(HALF);
    cs = 1'b1;
    step(2 * HALF + 4);
  endtask

  int base_ovr, base_ferr, base_vld, base_busy, base_acc;

  task automatic snap();
    base_ovr  = ovr_cnt;
    base_ferr = ferr_cnt;
    base_vld  = vld_cyc;
    base_busy = busy_cyc;
    base_acc  = acc_q.size();
  endtask

  initial begin
    logic [DATA_W-1:0] w0;
    logic [DATA_W-1:0] rw [3];
    int                nw, np, exp_cnt;
    logic              rr;

    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; cs = 1'b1; rx_ready = 1'b0;
    step(5);
    rst = 1'b0;
    step(2);
    check("rst_valid", int'(rx_valid), 0);
    check("rst_data", int'(rx_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ovr", int'(overrun), 0);
    check("rst_ferr", int'(frame_err), 0);

    // Single 0xA5 word, consumer always ready.
    snap();
    rx_ready = 1'b1;
    frame_start();
    check("a5_busy", int'(busy), 1);
    send_word(8'hA5);
    frame_end();
    check("a5_cnt", acc_q.size() - base_acc, 1);
    if (acc_q.size() > base_acc) check("a5_data", int'(acc_q[base_acc]), 'hA5);
    check("a5_vldcyc", vld_cyc - base_vld, 1);
    check("a5_ovr", ovr_cnt - base_ovr, 0);
    check("a5_ferr", ferr_cnt - base_ferr, 0);
    check("a5_idle", int'(busy), 0);

    // Two words, consumer stalled: second word dropped with overrun.
    snap();
    rx_ready = 1'b0;
    frame_start();
    send_word(8'h3C);
    send_word(8'hC3);
    frame_end();
    check("ovr_data", int'(rx_data), 'h3C);
    check("ovr_valid", int'(rx_valid), 1);
    check("ovr_cnt", ovr_cnt - base_ovr, 1);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    step(1);
    check("ovr_drain", int'(rx_valid), 0);
    check("ovr_acc", acc_q.size() - base_acc, 1);
    if (acc_q.size() > base_acc) check("ovr_word", int'(acc_q[base_acc]), 'h3C);

    // Consumer accepts the held word on the exact completion cycle of 0xC3.
    snap();
    rx_ready = 1'b0;
    frame_start();
    send_word(8'h3C);
    w0 = 8'hC3;
    for (int i = DATA_W - 1; i >= 1; i--) spi_bit(w0[i]);
    mosi = w0[0];
    step(HALF);
    sclk = 1'b1;
    step(SYNC);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    step(HALF - SYNC - 1);
    sclk = 1'b0;
    frame_end();
    check("same_data", int'(rx_data), 'hC3);
    check("same_valid", int'(rx_valid), 1);
    check("same_ovr", ovr_cnt - base_ovr, 0);
    check("same_acc", acc_q.size() - base_acc, 1);
    if (acc_q.size() > base_acc) check("same_word", int'(acc_q[base_acc]), 'h3C);
    rx_ready = 1'b1;
    step(2);

    // Truncated frame then a good one.
    snap();
    frame_start();
    for (int i = 0; i < 5; i++) spi_bit(1'($urandom_range(0, 1)));
    frame_end();
    check("trunc_ferr", ferr_cnt - base_ferr, 1);
    check("trunc_vld", vld_cyc - base_vld, 0);
    frame_start();
    send_word(8'h81);
    frame_end();
    check("after_cnt", acc_q.size() - base_acc, 1);
    if (acc_q.size() > base_acc) check("after_data", int'(acc_q[base_acc]), 'h81);

    // sclk activity with cs high is ignored.
    snap();
    for (int i = 0; i < 16; i++) begin
      mosi = 1'($urandom_range(0, 1));
      sclk = ~sclk;
      step(HALF);
    end
    step(6);
    check("cshi_vld", vld_cyc - base_vld, 0);
    check("cshi_busy", busy_cyc - base_busy, 0);

    // Reset mid-word, then a fresh frame.
    snap();
    frame_start();
    for (int i = 0; i < 4; i++) spi_bit(1'b1);
    rst = 1'b1;
    cs = 1'b1;
    sclk = 1'b0;
    step(3);
    rst = 1'b0;
    step(4);
    check("mrst_valid", int'(rx_valid), 0);
    check("mrst_busy", int'(busy), 0);
    frame_start();
    send_word(8'h5A);
    frame_end();
    check("mrst_ferr", ferr_cnt - base_ferr, 0);
    check("mrst_cnt", acc_q.size() - base_acc, 1);
    if (acc_q.size() > base_acc) check("mrst_data", int'(acc_q[base_acc]), 'h5A);

    // Randomized frames against a word-level model.
    for (int it = 0; it < 6; it++) begin
      nw = $urandom_range(1, 3);
      np = $urandom_range(0, 3);
      rr = 1'($urandom_range(0, 1));
      for (int k = 0; k < 3; k++) rw[k] = DATA_W'($urandom);
      snap();
      rx_ready = rr;
      frame_start();
      for (int k = 0; k < nw; k++) send_word(rw[k]);
      for (int k = 0; k < np; k++) spi_bit(1'($urandom_range(0, 1)));
      frame_end();
      rx_ready = 1'b1;
      step(3);
      rx_ready = 1'b0;
      step(2);
      exp_cnt = rr ? nw : 1;
      check("rnd_ovr", ovr_cnt - base_ovr, rr ? 0 : nw - 1);
      check("rnd_ferr", ferr_cnt - base_ferr, (np != 0) ? 1 : 0);
      check("rnd_cnt", acc_q.size() - base_acc, exp_cnt);
      for (int k = 0; k < exp_cnt; k++)
        if (base_acc + k < acc_q.size())
          check("rnd_word", int'(acc_q[base_acc + k]), int'(rw[k]));
    end

    check("hold", hold_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the bits per word.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the flip-flop depth of each input synchronizer (minimum 2).
REQ-003 Parameter CPOL, default 0, SHALL set the sclk idle level.
REQ-004 Parameter CPHA, default 0, SHALL select the sample edge: leading edge when 0, trailing edge when 1.
REQ-005 Parameter MSB_FIRST, default 1, SHALL select MSB-first shifting when 1 and LSB-first when 0.
REQ-006 clk  input  1  single system clock; all state SHALL be updated on its rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 sclk  input  1  SPI serial clock, asynchronous to clk.
REQ-009 mosi  input  1  serial data from the master, asynchronous to clk.
REQ-010 cs  input  1  chip select, active-low, asynchronous to clk.
REQ-011 rx_data  output  DATA_W  received word; valid only while rx_valid=1.
REQ-012 rx_valid  output  1  a word is held in rx_data.
REQ-013 rx_ready  input  1  consumer accepts the word on a cycle where rx_valid=1 and rx_ready=1.
REQ-014 overrun  output  1  one-cycle pulse: a completed word was dropped.
REQ-015 frame_err  output  1  one-cycle pulse: cs deasserted mid-word.
REQ-016 busy  output  1  high while the FSM is in ACTIVE.

Function
REQ-017 sclk, mosi and cs SHALL each pass through a SYNC_STAGES synchronizer before any use.
REQ-018 Edges SHALL be detected by comparing the synchronized sclk with a one-cycle delayed copy; only edges seen while the synchronized cs=0 SHALL count.
REQ-019 FSM states SHALL be IDLE and ACTIVE.
- IDLE->ACTIVE on synchronized cs falling.
- ACTIVE->IDLE on synchronized cs rising.
REQ-020 In ACTIVE, each sample edge SHALL shift synchronized mosi into the shift register and increment bit_cnt.
REQ-021 When bit_cnt reaches DATA_W:
- the word SHALL transfer to the output register;
- bit_cnt SHALL wrap to 0;
- back-to-back words within one cs frame SHALL be received without gaps.
REQ-022 rx_valid SHALL rise no more than SYNC_STAGES+2 clk cycles after the final sample edge at the pin.
REQ-023 Once set, rx_valid SHALL stay high and rx_data SHALL stay stable until the word is accepted.
REQ-024 If a word completes while rx_valid=1 and rx_ready=0:
- the new word SHALL be dropped;
- rx_data SHALL keep the old word;
- overrun SHALL pulse for one cycle.
REQ-025 If a word completes in the same cycle the held word is accepted, the new word SHALL load, rx_valid SHALL stay 1, and overrun SHALL NOT pulse.
REQ-026 On cs rising with bit_cnt != 0:
- frame_err SHALL pulse for one cycle;
- the partial word SHALL be discarded;
- bit_cnt SHALL clear;
- rx_valid and rx_data SHALL be unaffected.
REQ-027 On cs rising with bit_cnt = 0, frame_err SHALL NOT pulse.
REQ-028 sclk edges while cs is high SHALL be ignored.
REQ-029 Correct operation SHALL be guaranteed only when the sclk high and low phases each last at least SYNC_STAGES+2 clk cycles; the team master's 8-clk-per-bit sclk satisfies this.

Reset
REQ-030 Reset SHALL force the FSM to IDLE and clear bit_cnt, the shift register, rx_data and all synchronizer stages.
REQ-031 Reset values SHALL be: rx_data=0, rx_valid=0, overrun=0, frame_err=0, busy=0; synchronizer stages for cs SHALL reset to 1 and for sclk to CPOL.
REQ-032 Reset asserted mid-word SHALL discard the partial word without a frame_err pulse; after reset, reception SHALL restart only on a fresh cs falling edge.

Structure
REQ-033 Package spi_pkg SHALL hold the FSM state enum (IDLE, ACTIVE) and the mode constants (CPOL/CPHA encodings).
REQ-034 Sub-module spi_sync (an N-stage synchronizer with parameterized reset value) SHALL be instantiated once each for sclk, mosi and cs.

Verification
REQ-035 The bench SHALL cover:
- cs low, 8 bits 0xA5 MSB-first at 8 clk/bit, rx_ready=1 -> one rx_valid cycle with rx_data=0xA5; no overrun or frame_err.
- One cs frame carrying 0x3C then 0xC3, rx_ready=0 -> rx_data=0x3C held, overrun pulses once when 0xC3 completes; after rx_ready=1, rx_valid falls.
- Same frame with rx_ready pulsed on the exact completion cycle of 0xC3 -> rx_data becomes 0xC3, rx_valid stays 1, no overrun.
- cs raised after 5 bits -> frame_err pulses once, no rx_valid; next full frame 0x81 -> rx_data=0x81.
- sclk toggling 16 times with cs high -> no rx_valid and busy=0.
- rst asserted after 4 bits of 0xFF, then a fresh frame with 0x5A -> no frame_err, rx_data=0x5A.
